// File: rtl/matrix_scalar_div.sv
// matrix_scalar_div
// Divides every element of an m x n matrix (at most 5x5, unsigned 8-bit
// elements) by an unsigned 4-bit scalar. One restoring-division step runs per
// clock, so each element takes 8 cycles and elements are handled in row-major
// order.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous active-high reset
//   start        request pulse, only looked at while idle
//   m, n         row / column count, legal range 1..5
//   scalarValue  divisor, legal range 1..15
//   matrices_in  matrix A in [199:0], element (i,j) at bit (i*5+j)*8
//   matrices_out registered quotients, same packing, [399:200] always 0
//   busy         high while division steps are running
//   done         one-cycle pulse at completion or rejection
//   valid        matrices_out holds a good result
//   error        last request was rejected
//   inexact      some active element left a nonzero remainder
module matrix_scalar_div (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   m,
  input  logic [2:0]   n,
  input  logic [3:0]   scalarValue,
  input  logic [399:0] matrices_in,
  output logic [399:0] matrices_out,
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic         error,
  output logic         inexact
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  // Captured request and running datapath state
  logic [199:0] a_reg;
  logic [199:0] q_out;
  logic [2:0]   m_reg;
  logic [2:0]   n_reg;
  logic [3:0]   div_reg;
  logic [2:0]   i_idx;
  logic [2:0]   j_idx;
  logic [2:0]   bit_cnt;
  logic [4:0]   rem_reg;
  logic [7:0]   quo_reg;
  logic         valid_reg;
  logic         error_reg;
  logic         inexact_reg;

  // Combinational step signals
  logic         req_legal;
  logic [4:0]   elem_idx;
  logic [7:0]   elem_off;
  logic [7:0]   cur_elem;
  logic         cur_bit;
  logic [4:0]   shifted;
  logic [4:0]   rem_next;
  logic         q_bit;
  logic [7:0]   quo_next;
  logic         elem_last_bit;
  logic         last_elem;

  // The upper half of matrices_in carries no information for this block
  logic unused_upper;
  assign unused_upper = ^matrices_in[399:200];

  // One restoring-division step on the current element. The remainder is
  // always below the divisor (<= 14), so only its low 4 bits need shifting.
  always_comb begin
    req_legal     = (m != 3'd0) && (m <= 3'd5) && (n != 3'd0) && (n <= 3'd5) &&
                    (scalarValue != 4'd0);
    elem_idx      = ({2'b00, i_idx} * 5'd5) + {2'b00, j_idx};
    elem_off      = {elem_idx, 3'b000};
    cur_elem      = a_reg[elem_off +: 8];
    cur_bit       = cur_elem[bit_cnt];
    shifted       = {rem_reg[3:0], cur_bit};
    rem_next      = shifted;
    q_bit         = 1'b0;
    if (shifted >= {1'b0, div_reg}) begin
      rem_next = shifted - {1'b0, div_reg};
      q_bit    = 1'b1;
    end
    quo_next      = {quo_reg[6:0], q_bit};
    elem_last_bit = (bit_cnt == 3'd0);
    last_elem     = (i_idx == (m_reg - 3'd1)) && (j_idx == (n_reg - 3'd1));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: an illegal request goes straight to DONE so the
  // requester still sees a done pulse.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = req_legal ? DIV : DONE;
      end
      DIV: begin
        if (elem_last_bit && last_elem) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy = (state == DIV);
    done = (state == DONE);
  end

  // Datapath: capture on accepted start, step during DIV. Result flags are
  // only touched on a start or at the end of a job so they hold in between.
  // valid rises as DONE is entered so it is already up during the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg       <= '0;
      q_out       <= '0;
      m_reg       <= '0;
      n_reg       <= '0;
      div_reg     <= '0;
      i_idx       <= '0;
      j_idx       <= '0;
      bit_cnt     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      valid_reg   <= 1'b0;
      error_reg   <= 1'b0;
      inexact_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_out       <= '0;
            valid_reg   <= 1'b0;
            inexact_reg <= 1'b0;
            i_idx       <= '0;
            j_idx       <= '0;
            bit_cnt     <= 3'd7;
            rem_reg     <= '0;
            quo_reg     <= '0;
            if (req_legal) begin
              a_reg     <= matrices_in[199:0];
              m_reg     <= m;
              n_reg     <= n;
              div_reg   <= scalarValue;
              error_reg <= 1'b0;
            end else begin
              error_reg <= 1'b1;
            end
          end
        end
        DIV: begin
          if (elem_last_bit) begin
            q_out[elem_off +: 8] <= quo_next;
            inexact_reg <= inexact_reg | (rem_next != 5'd0);
            rem_reg     <= '0;
            quo_reg     <= '0;
            bit_cnt     <= 3'd7;
            if (last_elem) begin
              valid_reg <= 1'b1;
            end else if (j_idx == (n_reg - 3'd1)) begin
              j_idx <= '0;
              i_idx <= i_idx + 3'd1;
            end else begin
              j_idx <= j_idx + 3'd1;
            end
          end else begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign matrices_out = {200'd0, q_out};
  assign valid        = valid_reg;
  assign error        = error_reg;
  assign inexact      = inexact_reg;

endmodule

// File: tb/tb_matrix_scalar_div.sv
// tb_matrix_scalar_div
// Self-checking bench for matrix_scalar_div. Expected results come from a
// behavioural divide model, are queued when a job is launched and popped when
// the done pulse appears.
module tb_matrix_scalar_div;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   m;
  logic [2:0]   n;
  logic [3:0]   scalarValue;
  logic [399:0] matrices_in;
  logic [399:0] matrices_out;
  logic         busy;
  logic         done;
  logic         valid;
  logic         error;
  logic         inexact;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [399:0] out;
    logic         inexact;
    logic         error;
    int           latency;
  } exp_t;

  exp_t sb[$];

  matrix_scalar_div dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .m            (m),
    .n            (n),
    .scalarValue  (scalarValue),
    .matrices_in  (matrices_in),
    .matrices_out (matrices_out),
    .busy         (busy),
    .done         (done),
    .valid        (valid),
    .error        (error),
    .inexact      (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: plain integer divide over the active window
  function automatic exp_t model(input logic [2:0] mm, input logic [2:0] nn,
                                 input logic [3:0] s, input logic [399:0] mat);
    exp_t e;
    int a;
    int sv;
    e.out     = '0;
    e.inexact = 1'b0;
    e.error   = 1'b0;
    e.latency = 0;
    if (mm == 0 || mm > 5 || nn == 0 || nn > 5 || s == 0) begin
      e.error = 1'b1;
      return e;
    end
    sv = int'(s);
    for (int i = 0; i < int'(mm); i++) begin
      for (int j = 0; j < int'(nn); j++) begin
        a = int'(mat[(i*5+j)*8 +: 8]);
        e.out[(i*5+j)*8 +: 8] = 8'(a / sv);
        if ((a % sv) != 0) e.inexact = 1'b1;
      end
    end
    e.latency = 8 * int'(mm) * int'(nn);
    return e;
  endfunction

  // Launch one job, optionally inject a second start with different data at
  // DIV cycle inject_at, then wait for done and compare against the queue.
  // Afterwards watch hold_cycles more cycles for stray done pulses and
  // confirm the results are held.
  task automatic run_job(input string name, input logic [2:0] jm, input logic [2:0] jn,
                         input logic [3:0] js, input logic [399:0] jmat,
                         input int inject_at, input int hold_cycles);
    exp_t e;
    int cyc;
    int busy_cnt;
    int extra_done;
    bit done_seen;
    sb.push_back(model(jm, jn, js, jmat));
    @(negedge clk);
    m = jm; n = jn; scalarValue = js; matrices_in = jmat; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; busy_cnt = 0; done_seen = 0;
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      if (cyc == inject_at) begin
        start = 1'b1; m = 3'd1; n = 3'd1; scalarValue = 4'd7; matrices_in = ~jmat;
      end else begin
        start = 1'b0;
      end
      if (done) done_seen = 1;
      else begin
        if (busy) busy_cnt++;
        cyc++;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!done_seen) begin
      errors++;
      $display("[TB] FAIL %s done_timeout got none required within 400 cycles", name);
      return;
    end
    checks++;
    if (cyc !== e.latency) begin
      errors++;
      $display("[TB] FAIL %s latency got %0d required %0d", name, cyc, e.latency);
    end
    checks++;
    if (busy_cnt !== e.latency) begin
      errors++;
      $display("[TB] FAIL %s busy_cycles got %0d required %0d", name, busy_cnt, e.latency);
    end
    extra_done = 0;
    for (int k = 0; k < hold_cycles; k++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    checks++;
    if (extra_done !== 0) begin
      errors++;
      $display("[TB] FAIL %s extra_done got %0d required 0", name, extra_done);
    end
    checks++;
    if (matrices_out !== e.out) begin
      errors++;
      $display("[TB] FAIL %s matrices_out got %h required %h", name, matrices_out, e.out);
    end
    checks++;
    if (error !== e.error) begin
      errors++;
      $display("[TB] FAIL %s error got %b required %b", name, error, e.error);
    end
    checks++;
    if (valid !== !e.error) begin
      errors++;
      $display("[TB] FAIL %s valid got %b required %b", name, valid, !e.error);
    end
    checks++;
    if (inexact !== e.inexact) begin
      errors++;
      $display("[TB] FAIL %s inexact got %b required %b", name, inexact, e.inexact);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (matrices_out !== '0 || busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0 ||
        error !== 1'b0 || inexact !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s outputs got out=%h busy=%b done=%b valid=%b error=%b inexact=%b required all 0",
               name, matrices_out, busy, done, valid, error, inexact);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; m = 3'd0; n = 3'd0; scalarValue = 4'd0; matrices_in = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset_release");
  endtask

  task automatic test_2x2();
    logic [399:0] mat;
    mat = '0;
    mat[0*8 +: 8] = 8'd10;
    mat[1*8 +: 8] = 8'd20;
    mat[5*8 +: 8] = 8'd30;
    mat[6*8 +: 8] = 8'd40;
    run_job("div_2x2", 3'd2, 3'd2, 4'd3, mat, -1, 3);
    checks++;
    if (matrices_out[0 +: 64] !== {8'd13, 8'd10, 24'd0, 8'd6, 8'd3}) begin
      errors++;
      $display("[TB] FAIL div_2x2_literal got %h required 0d0a00000000 0603", matrices_out[0 +: 64]);
    end
  endtask

  task automatic test_full_5x5();
    logic [399:0] mat;
    mat = {200'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()}), {25{8'd255}}};
    run_job("div_5x5_by1", 3'd5, 3'd5, 4'd1, mat, -1, 3);
  endtask

  task automatic test_reject();
    logic [399:0] mat;
    mat = {50{8'd77}};
    run_job("reject_scalar0", 3'd3, 3'd3, 4'd0, mat, -1, 3);
    run_job("good_before_m6", 3'd1, 3'd2, 4'd5, mat, -1, 2);
    run_job("reject_m6", 3'd6, 3'd3, 4'd0, mat, -1, 3);
    run_job("reject_n0", 3'd2, 3'd0, 4'd4, mat, -1, 3);
  endtask

  task automatic test_back_to_back();
    logic [399:0] mat;
    mat = {25{8'd200}};
    mat[0 +: 8] = 8'd199;
    run_job("start_during_busy", 3'd3, 3'd2, 4'd9, mat, 10, 60);
  endtask

  task automatic test_random();
    logic [399:0] mat;
    logic [2:0] rm;
    logic [2:0] rn;
    logic [3:0] rs;
    for (int t = 0; t < 4; t++) begin
      for (int w = 0; w < 13; w++) mat[w*32 +: 32] = $urandom();
      rm = 3'($urandom_range(1, 5));
      rn = 3'($urandom_range(1, 5));
      rs = 4'($urandom_range(1, 15));
      run_job($sformatf("random_%0d", t), rm, rn, rs, mat, -1, 2);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [399:0] mat;
    int cyc;
    mat = {50{8'd123}};
    @(negedge clk);
    m = 3'd3; n = 3'd3; scalarValue = 4'd7; matrices_in = mat; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    // Stop in the cycle where element 2 is about to process bit 4
    while (cyc < 19) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_op_busy got %b required 1", busy);
    end
    reset = 1'b1;
    #1;
    check_all_zero("reset_mid_op");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_mid_op_release");
    mat = '0;
    mat[7:0] = 8'd9;
    run_job("div_1x1_after_reset", 3'd1, 3'd1, 4'd4, mat, -1, 3);
  endtask

  initial begin
    test_reset();
    test_2x2();
    test_full_5x5();
    test_reject();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_left got %0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
